// File: rtl/ip_codma_beat_fifo.sv
// ip_codma_beat_fifo: FWFT staging FIFO between CODMA read and write paths with length tracking.
// Optional high-water-mark output hwm_o when CODMA_BEAT_FIFO_HWM_EN is defined.
module ip_codma_beat_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int LEN_W  = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic [LEN_W-1:0]         len_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    output logic                     push_ready_o,
    output logic                     pop_valid_o,
    output logic [DATA_W-1:0]        pop_data_o,
    input  logic                     pop_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     overflow_o
`ifdef CODMA_BEAT_FIFO_HWM_EN
    ,
    output logic [$clog2(DEPTH):0]   hwm_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, FILL, DRAIN, ERROR} state_t;
    state_t state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [LEN_W-1:0] len, pushed, popped, pushed_nx, popped_nx;
    logic full, push_ok, pop_ok;
    assign full         = count == CW'(DEPTH);
    assign pop_valid_o  = (state == FILL || state == DRAIN) && count != '0;
    assign pop_data_o   = pop_valid_o ? mem[rd_ptr] : '0;
    assign push_ready_o = state == FILL && (!full || (pop_valid_o && pop_ready_i));
    assign push_ok      = push_i && push_ready_o;
    assign pop_ok       = pop_valid_o && pop_ready_i;
    assign busy_o       = state != IDLE;
    assign count_o      = count;
    // beat counters saturate rather than wrap
    assign pushed_nx = (push_ok && !(&pushed)) ? pushed + LEN_W'(1) : pushed;
    assign popped_nx = (pop_ok && !(&popped)) ? popped + LEN_W'(1) : popped;
    always_ff @(posedge clk_i)
        if (push_ok) mem[wr_ptr] <= push_data_i;
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            len        <= '0;
            pushed     <= '0;
            popped     <= '0;
            done_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count  <= count + CW'(push_ok) - CW'(pop_ok);
            pushed <= pushed_nx;
            popped <= popped_nx;
            if (push_i && !push_ready_o) overflow_o <= 1'b1;
            case (state)
                IDLE:
                    if (start_i) begin
                        if (len_i == '0) done_o <= 1'b1;
                        else begin
                            len    <= len_i;
                            pushed <= '0;
                            popped <= '0;
                            state  <= FILL;
                        end
                    end
                FILL:
                    if (push_i && !push_ready_o) state <= ERROR;
                    else if (pushed_nx == len) state <= DRAIN;
                DRAIN:
                    if (popped_nx == len) begin
                        state  <= IDLE;
                        done_o <= 1'b1;
                    end
                ERROR: state <= ERROR;
            endcase
        end
    end
`ifdef CODMA_BEAT_FIFO_HWM_EN
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i || (state == IDLE && start_i)) hwm_o <= '0;
        else if (count > hwm_o) hwm_o <= count;
    end
`endif
endmodule

// File: tb/tb_ip_codma_beat_fifo.sv
// tb_ip_codma_beat_fifo: directed scenarios plus randomized transfers against a queue model.
module tb_ip_codma_beat_fifo;
    localparam int DEPTH = 8;
    logic clk = 0, reset_i, start_i, flush_i, push_i, pop_ready_i;
    logic [7:0] len_i;
    logic [63:0] push_data_i, pop_data_o;
    logic push_ready_o, pop_valid_o, busy_o, done_o, overflow_o;
    logic [3:0] count_o;
`ifdef CODMA_BEAT_FIFO_HWM_EN
    logic [3:0] hwm_o;
`endif
    int tests = 0, fails = 0;

    ip_codma_beat_fifo dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .len_i(len_i), .flush_i(flush_i),
        .push_i(push_i), .push_data_i(push_data_i), .push_ready_o(push_ready_o),
        .pop_valid_o(pop_valid_o), .pop_data_o(pop_data_o), .pop_ready_i(pop_ready_i),
        .count_o(count_o), .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
`ifdef CODMA_BEAT_FIFO_HWM_EN
        , .hwm_o(hwm_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start_i = 0; flush_i = 0; push_i = 0; pop_ready_i = 0; len_i = 0; push_data_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_i = 1;
        next(); next();
        reset_i = 0;
        #1;
        tests++;
        if ({count_o, pop_valid_o, push_ready_o, busy_o, done_o, overflow_o} !== 9'd0 || pop_data_o !== 64'd0) begin
            fails++;
            $display("FAIL reset: count=%0d pv=%b pr=%b busy=%b done=%b ovf=%b data=%h, required all 0",
                     count_o, pop_valid_o, push_ready_o, busy_o, done_o, overflow_o, pop_data_o);
        end
    endtask

    task automatic test_basic();
        int dones = 0;
        idle_inputs();
        start_i = 1; len_i = 4;
        next();
        start_i = 0; pop_ready_i = 1;
        for (int k = 0; k < 5; k++) begin
            push_i = k < 4;
            push_data_i = 64'h1111 * (k + 1);
            #1;
            dones += done_o;
            if (k > 0) begin
                tests++;
                if (!pop_valid_o || pop_data_o !== 64'h1111 * k) begin
                    fails++;
                    $display("FAIL basic_pop%0d: valid=%b data=%h, required 1 %h", k, pop_valid_o, pop_data_o, 64'h1111 * k);
                end
            end
            next();
        end
        push_i = 0; pop_ready_i = 0;
        #1;
        tests++;
        if (done_o !== 1 || busy_o !== 0 || dones != 0) begin
            fails++;
            $display("FAIL basic_done: done=%b busy=%b early=%0d, required 1 0 0", done_o, busy_o, dones);
        end
        next();
        tests++;
        if (done_o !== 0) begin
            fails++;
            $display("FAIL basic_done_once: done=%b, required 0", done_o);
        end
    endtask

    task automatic test_full_concurrent();
        idle_inputs();
        start_i = 1; len_i = 10;
        next();
        start_i = 0;
        for (int k = 1; k <= 8; k++) begin
            push_i = 1; push_data_i = 64'(k);
            #1;
            tests++;
            if (push_ready_o !== 1) begin
                fails++;
                $display("FAIL full_fill%0d: push_ready=%b, required 1", k, push_ready_o);
            end
            next();
        end
        push_i = 0;
        #1;
        tests++;
        if (count_o !== 4'd8 || push_ready_o !== 0) begin
            fails++;
            $display("FAIL full_stop: count=%0d push_ready=%b, required 8 0", count_o, push_ready_o);
        end
        pop_ready_i = 1;
        for (int k = 1; k <= 10; k++) begin
            push_i = k <= 2;
            push_data_i = 64'(k + 8);
            #1;
            tests++;
            if (!pop_valid_o || pop_data_o !== 64'(k) || (k <= 2 && (push_ready_o !== 1 || count_o !== 4'd8))) begin
                fails++;
                $display("FAIL full_drain%0d: valid=%b data=%0d pr=%b count=%0d, required data %0d", k,
                         pop_valid_o, pop_data_o, push_ready_o, count_o, k);
            end
            next();
        end
        push_i = 0; pop_ready_i = 0;
        #1;
        tests++;
        if (done_o !== 1 || busy_o !== 0) begin
            fails++;
            $display("FAIL full_done: done=%b busy=%b, required 1 0", done_o, busy_o);
        end
        next();
    endtask

    task automatic test_overflow_error();
        idle_inputs();
        start_i = 1; len_i = 10;
        next();
        start_i = 0; push_i = 1;
        for (int k = 0; k < 8; k++) begin
            push_data_i = 64'(k);
            next();
        end
        next();
        push_i = 0;
        #1;
        tests++;
        if (overflow_o !== 1 || pop_valid_o !== 0 || busy_o !== 1 || count_o !== 4'd8) begin
            fails++;
            $display("FAIL error_state: ovf=%b pv=%b busy=%b count=%0d, required 1 0 1 8", overflow_o, pop_valid_o, busy_o, count_o);
        end
        flush_i = 1; start_i = 1; len_i = 3;
        next();
        flush_i = 0; start_i = 0;
        #1;
        tests++;
        if (count_o !== 0 || overflow_o !== 0 || busy_o !== 0) begin
            fails++;
            $display("FAIL flush: count=%0d ovf=%b busy=%b, required 0 0 0", count_o, overflow_o, busy_o);
        end
    endtask

    task automatic test_zero_len();
        idle_inputs();
        start_i = 1; len_i = 0;
        next();
        start_i = 0; push_i = 1; push_data_i = 64'hdead;
        #1;
        tests++;
        if (done_o !== 1 || busy_o !== 0 || push_ready_o !== 0) begin
            fails++;
            $display("FAIL zero_len: done=%b busy=%b pr=%b, required 1 0 0", done_o, busy_o, push_ready_o);
        end
        next();
        push_i = 0;
        #1;
        tests++;
        if (done_o !== 0 || count_o !== 0 || overflow_o !== 1) begin
            fails++;
            $display("FAIL zero_len_after: done=%b count=%0d ovf=%b, required 0 0 1", done_o, count_o, overflow_o);
        end
        flush_i = 1;
        next();
        flush_i = 0;
    endtask

    task automatic test_reset_mid_drain();
        idle_inputs();
        start_i = 1; len_i = 3;
        next();
        start_i = 0; push_i = 1;
        for (int k = 0; k < 3; k++) begin
            push_data_i = 64'(k + 100);
            next();
        end
        push_i = 0;
        #1;
        tests++;
        if (count_o !== 4'd3 || busy_o !== 1 || push_ready_o !== 0) begin
            fails++;
            $display("FAIL drain_setup: count=%0d busy=%b pr=%b, required 3 1 0", count_o, busy_o, push_ready_o);
        end
        reset_i = 1; pop_ready_i = 1;
        next();
        reset_i = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            tests++;
            if ({count_o, pop_valid_o, push_ready_o, busy_o, done_o, overflow_o} !== 9'd0 || pop_data_o !== 0) begin
                fails++;
                $display("FAIL reset_mid_drain%0d: count=%0d pv=%b pr=%b busy=%b done=%b ovf=%b, required all 0",
                         k, count_o, pop_valid_o, push_ready_o, busy_o, done_o, overflow_o);
            end
            next();
        end
        pop_ready_i = 0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            logic [63:0] q[$];
            int len = $urandom_range(1, 20);
            int pushed = 0, popped = 0, cyc = 0;
            bit exp_done = 0, exp_busy = 1, ok = 1, fin = 0;
            idle_inputs();
            start_i = 1; len_i = 8'(len);
            next();
            start_i = 0;
            while (!fin && cyc < 300) begin
                bit rdy_exp, pop_now;
                pop_ready_i = $urandom_range(0, 1);
                rdy_exp = pushed < len && (q.size() < DEPTH || (q.size() > 0 && pop_ready_i));
                push_i = rdy_exp && $urandom_range(0, 3) != 0;
                push_data_i = {$urandom, $urandom};
                #1;
                tests++;
                if (push_ready_o !== rdy_exp || pop_valid_o !== (q.size() > 0) || count_o !== 4'(q.size())
                    || done_o !== exp_done || busy_o !== exp_busy || (q.size() > 0 && pop_data_o !== q[0])) begin
                    fails++; ok = 0;
                    $display("FAIL random t%0d c%0d: pr=%b pv=%b data=%h count=%0d done=%b busy=%b, required %b %b %h %0d %b %b",
                             t, cyc, push_ready_o, pop_valid_o, pop_data_o, count_o, done_o, busy_o,
                             rdy_exp, q.size() > 0, q.size() > 0 ? q[0] : 64'd0, q.size(), exp_done, exp_busy);
                end
                fin = exp_done || !ok;
                pop_now = exp_busy && q.size() > 0 && pop_ready_i;
                exp_done = 0;
                if (pop_now) begin
                    void'(q.pop_front());
                    popped++;
                    if (popped == len) begin exp_done = 1; exp_busy = 0; end
                end
                if (push_i) begin q.push_back(push_data_i); pushed++; end
                next();
                cyc++;
            end
            if (!fin) begin
                tests++; fails++;
                $display("FAIL random_timeout t%0d: popped=%0d, required %0d", t, popped, len);
                reset_i = 1; next(); reset_i = 0;
            end
        end
        idle_inputs();
    endtask

`ifdef CODMA_BEAT_FIFO_HWM_EN
    task automatic test_hwm();
        idle_inputs();
        start_i = 1; len_i = 5;
        next();
        start_i = 0; push_i = 1;
        for (int k = 0; k < 5; k++) begin
            push_data_i = 64'(k);
            next();
        end
        push_i = 0; pop_ready_i = 1;
        for (int k = 0; k < 8; k++) next();
        pop_ready_i = 0;
        tests++;
        if (hwm_o !== 4'd5 || busy_o !== 0) begin
            fails++;
            $display("FAIL hwm_hold: hwm=%0d busy=%b, required 5 0", hwm_o, busy_o);
        end
        flush_i = 1;
        next();
        flush_i = 0;
        #1;
        tests++;
        if (hwm_o !== 4'd0) begin
            fails++;
            $display("FAIL hwm_flush: hwm=%0d, required 0", hwm_o);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_full_concurrent();
        test_overflow_error();
        test_zero_len();
        test_reset_mid_drain();
        test_random();
`ifdef CODMA_BEAT_FIFO_HWM_EN
        test_hwm();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ip_codma_beat_fifo.md
Name: ip_codma_beat_fifo

Overview:
- Data staging buffer between the CODMA read path and write path.
- Captures 64-bit read beats returned by the bus during a read phase.
- Holds them in a first-word-fall-through FIFO and presents them to the write path with valid/ready.
- Tracks a programmed transfer length and pulses done once that many beats have been popped.

Parameters:
DATA_W, 64, beat width in bits (two 32-bit words)
DEPTH, 8, FIFO entries; power of two, >= 2
LEN_W, 8, width of transfer-length and beat counters

Ports:
clk_i  input  1  clock, rising edge
reset_i  input  1  synchronous active-high reset
start_i  input  1  single-cycle pulse: begin transfer of len_i beats
len_i  input  LEN_W  beat count for the transfer; sampled on start_i
flush_i  input  1  abort (CPU stop); discards contents
push_i  input  1  bus read beat valid
push_data_i  input  DATA_W  bus read beat data
push_ready_o  output  1  FIFO can accept a beat this cycle
pop_valid_o  output  1  head entry valid
pop_data_o  output  DATA_W  head entry data
pop_ready_i  input  1  write path consumes head this cycle
count_o  output  $clog2(DEPTH)+1  current occupancy
busy_o  output  1  transfer in progress
done_o  output  1  single-cycle pulse: transfer complete
overflow_o  output  1  sticky: push attempted while not ready

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high; sampled on the rising edge.
- Reset values: state IDLE, pointers 0, count_o 0, pop_valid_o 0, pop_data_o 0, push_ready_o 0, busy_o 0, done_o 0, overflow_o 0, both beat counters 0.
- States: IDLE, FILL, DRAIN, ERROR.
- IDLE:
  - push_ready_o=0; pushes are ignored and set overflow_o.
  - start_i with len_i!=0: latch len, clear counters -> FILL.
  - start_i with len_i==0: done_o pulses next cycle; stay IDLE.
- FILL:
  - push_ready_o = !full | (pop_valid_o & pop_ready_i).
  - Each accepted push increments pushed_cnt.
  - When pushed_cnt reaches len -> DRAIN.
- DRAIN:
  - push_ready_o=0; further pushes set overflow_o.
  - When popped_cnt reaches len: done_o=1 for one cycle, busy_o drops the same cycle -> IDLE.
- ERROR:
  - Entered from FILL on push_i & !push_ready_o.
  - overflow_o=1; FIFO contents frozen; pop_valid_o=0.
  - Exit only via flush_i or reset_i -> IDLE.
- busy_o=1 in FILL, DRAIN and ERROR.
- Pops are allowed in FILL and DRAIN: pop occurs when pop_valid_o & pop_ready_i; popped_cnt increments.
- Latency: first-word-fall-through; a beat pushed at edge N is visible on pop_valid_o/pop_data_o after edge N (same cycle as the registered write). Push-to-pop minimum is 1 cycle.
- pop_data_o holds its value while pop_valid_o=1 and pop_ready_i=0.
- Full with simultaneous push and pop: both occur; count unchanged.
- Empty with simultaneous push and pop: pop is invalid (pop_valid_o=0); push is accepted.
- Pointers wrap modulo DEPTH. count_o = pushed-minus-popped, range 0..DEPTH.
- Counters saturate at 2^LEN_W-1; never wrap.
- flush_i (priority below reset_i, above everything else): next cycle pointers, count and counters are 0, state IDLE, and overflow_o is cleared. A simultaneous start_i is ignored.
- start_i outside IDLE: ignored.
- Reset mid-transfer: all state cleared; done_o does not pulse.

Optional Feature:
- Macro: CODMA_BEAT_FIFO_HWM_EN.
- Defined:
  - Adds output hwm_o, width $clog2(DEPTH)+1: the maximum count_o since the last start_i or flush_i.
  - Reset value 0; updates the cycle after count_o exceeds it.
- Undefined: port absent; no extra logic.

Test Plan:
- start_i with len_i=4, push 4 beats 0x1111..0x4444 on consecutive cycles, pop_ready_i=1 -> pop_data_o sequence 0x1111,0x2222,0x3333,0x4444 with one-cycle latency; done_o pulses exactly once after the 4th pop; busy_o then 0.
- DEPTH=8, len_i=10, pop_ready_i=0 -> push_ready_o drops after 8 pushes, count_o=8. Then raise pop_ready_i with push_i held -> push and pop concurrent, count_o stays 8, all 10 beats delivered in order.
- FILL with full FIFO and pop_ready_i=0, push_i=1 -> state ERROR, overflow_o=1, pop_valid_o=0. Then flush_i -> next cycle count_o=0, overflow_o=0, busy_o=0.
- start_i with len_i=0 -> done_o pulse the next cycle; busy_o stays 0; no push accepted.
- Assert reset_i mid-DRAIN with count_o=3 -> next cycle all outputs at reset values; no done_o pulse.
- With CODMA_BEAT_FIFO_HWM_EN defined: push 5 beats, pop all -> hwm_o=5 held. After flush_i -> hwm_o=0.
